// File: rtl/fir_xifu_simd_mac.sv
// SIMD multiply-accumulate execute engine for the FIR XIF coprocessor.
// Two stages: S1 registers per-lane products, S2 accumulates or reads out and
// retires in order into a result register, gated by per-entry commit/kill.
module fir_xifu_simd_mac #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NB_LANES = 2,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned NB_ACC   = 4,
  parameter int unsigned ID_W     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [1:0]                issue_op_i,
  input  logic [ID_W-1:0]           issue_id_i,
  input  logic [$clog2(NB_ACC)-1:0] issue_acc_i,
  input  logic [31:0]               issue_rs1_i,
  input  logic [31:0]               issue_rs2_i,
  input  logic [5:0]                issue_shift_i,
  input  logic                      commit_valid_i,
  input  logic [ID_W-1:0]           commit_id_i,
  input  logic                      commit_kill_i,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [ID_W-1:0]           result_id_o,
  output logic                      result_we_o,
  output logic [31:0]               result_data_o,
  output logic                      busy_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned AIDX_W = $clog2(NB_ACC);
  localparam int unsigned EXT_W  = ACC_W + 1;

  localparam logic [1:0] OP_MAC   = 2'd0;
  localparam logic [1:0] OP_CLR   = 2'd1;
  localparam logic [1:0] OP_RD    = 2'd2;
  localparam logic [1:0] OP_RDCLR = 2'd3;

  logic                             s1_valid, s1_cmt;
  logic [1:0]                       s1_op;
  logic [ID_W-1:0]                  s1_id;
  logic [AIDX_W-1:0]                s1_acc;
  logic [5:0]                       s1_shift;
  logic [NB_LANES-1:0][PROD_W-1:0]  s1_prod;

  logic                             s2_valid, s2_cmt;
  logic [1:0]                       s2_op;
  logic [ID_W-1:0]                  s2_id;
  logic [AIDX_W-1:0]                s2_acc;
  logic [5:0]                       s2_shift;
  logic [NB_LANES-1:0][PROD_W-1:0]  s2_prod;

  logic [ACC_W-1:0]                 acc_q [NB_ACC];

  logic                             hit_iss, hit_s1, hit_s2, s2_kill;
  logic                             s2_retire, s2_free, s1_adv, issue_fire;
  logic [NB_LANES-1:0][PROD_W-1:0]  prod_d;
  logic signed [PROD_W-1:0]         a_ext, b_ext;
  logic [ACC_W-1:0]                 sum, acc_cur;
  logic [5:0]                       sh;
  logic [EXT_W-1:0]                 rnd;
  logic signed [EXT_W-1:0]          rounded;
  logic [EXT_W-32:0]                hi;
  logic [31:0]                      rd_val;

  // Commit/kill matching and stage-advance handshakes
  assign hit_iss    = commit_valid_i && (commit_id_i == issue_id_i);
  assign hit_s1     = commit_valid_i && s1_valid && (commit_id_i == s1_id);
  assign hit_s2     = commit_valid_i && s2_valid && (commit_id_i == s2_id);
  assign s2_kill    = hit_s2 && commit_kill_i;
  assign s2_retire  = s2_valid && s2_cmt && !s2_kill && !clear_i &&
                      (!result_valid_o || result_ready_i);
  assign s2_free    = !s2_valid || s2_retire || s2_kill;
  assign s1_adv     = s1_valid && s2_free;
  assign issue_ready_o = !s1_valid || s1_adv;
  assign issue_fire = issue_valid_i && issue_ready_o && !clear_i;
  assign busy_o     = s1_valid || s2_valid || result_valid_o;

  // Per-lane signed products of the issuing operands
  always_comb begin
    prod_d = '0;
    a_ext  = '0;
    b_ext  = '0;
    for (int l = 0; l < int'(NB_LANES); l++) begin
      a_ext     = PROD_W'($signed(issue_rs1_i[l*DATA_W +: DATA_W]));
      b_ext     = PROD_W'($signed(issue_rs2_i[l*DATA_W +: DATA_W]));
      prod_d[l] = a_ext * b_ext;
    end
  end

  // Lane sum plus rounded, shifted, saturated readout of the S2 accumulator
  always_comb begin
    sum = '0;
    for (int l = 0; l < int'(NB_LANES); l++) begin
      sum = sum + ACC_W'($signed(s2_prod[l]));
    end
    acc_cur = acc_q[s2_acc];
    sh      = ({1'b0, s2_shift} >= 7'(ACC_W)) ? 6'(ACC_W - 1) : s2_shift;
    rnd     = '0;
    if (sh != 6'd0) rnd = EXT_W'(1) << (sh - 6'd1);
    rounded = $signed({acc_cur[ACC_W-1], acc_cur} + rnd) >>> sh;
    hi      = rounded[EXT_W-1:31];
    if ((&hi) || !(|hi)) rd_val = rounded[31:0];
    else                 rd_val = rounded[EXT_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // S1: capture issue, track commit/kill while waiting to advance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_cmt   <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
      s1_acc   <= '0;
      s1_shift <= '0;
      s1_prod  <= '0;
    end else if (clear_i) begin
      s1_valid <= 1'b0;
      s1_cmt   <= 1'b0;
    end else if (issue_fire) begin
      s1_valid <= !(hit_iss && commit_kill_i);
      s1_cmt   <= hit_iss && !commit_kill_i;
      s1_op    <= issue_op_i;
      s1_id    <= issue_id_i;
      s1_acc   <= issue_acc_i;
      s1_shift <= issue_shift_i;
      s1_prod  <= prod_d;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
      s1_cmt   <= 1'b0;
    end else if (hit_s1) begin
      if (commit_kill_i) s1_valid <= 1'b0;
      else               s1_cmt   <= 1'b1;
    end
  end

  // S2: holds the oldest entry until committed and the result slot is free
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_cmt   <= 1'b0;
      s2_op    <= '0;
      s2_id    <= '0;
      s2_acc   <= '0;
      s2_shift <= '0;
      s2_prod  <= '0;
    end else if (clear_i) begin
      s2_valid <= 1'b0;
      s2_cmt   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= !(hit_s1 && commit_kill_i);
      s2_cmt   <= s1_cmt || (hit_s1 && !commit_kill_i);
      s2_op    <= s1_op;
      s2_id    <= s1_id;
      s2_acc   <= s1_acc;
      s2_shift <= s1_shift;
      s2_prod  <= s1_prod;
    end else if (s2_retire || s2_kill) begin
      s2_valid <= 1'b0;
      s2_cmt   <= 1'b0;
    end else if (hit_s2) begin
      s2_cmt <= 1'b1;
    end
  end

  // Accumulator bank, updated only by a retiring S2 entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NB_ACC); i++) acc_q[i] <= '0;
    end else if (s2_retire) begin
      case (s2_op)
        OP_MAC:           acc_q[s2_acc] <= acc_cur + sum;
        OP_CLR, OP_RDCLR: acc_q[s2_acc] <= '0;
        default:          ;
      endcase
    end
  end

  // Result register, stable until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_we_o    <= 1'b0;
      result_data_o  <= '0;
    end else if (clear_i) begin
      result_valid_o <= 1'b0;
    end else if (s2_retire) begin
      result_valid_o <= 1'b1;
      result_id_o    <= s2_id;
      result_we_o    <= (s2_op == OP_RD) || (s2_op == OP_RDCLR);
      result_data_o  <= ((s2_op == OP_RD) || (s2_op == OP_RDCLR)) ? rd_val : 32'h0;
    end else if (result_ready_i) begin
      result_valid_o <= 1'b0;
    end
  end

endmodule
